// File: rtl/kbd_scan_ctrl.sv
// Keyboard scan-code sequencer: pops bytes from the PS/2 receiver FIFO, tracks
// break/extended prefixes, holds the current key and counts distinct presses.
module kbd_scan_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       ps2_data,
  input  logic             ps2_ready,
  input  logic             ps2_overflow,
  output logic             nextdata_n,
  output logic [7:0]       lut_code,
  input  logic [7:0]       lut_ascii,
  output logic [7:0]       key_code,
  output logic [7:0]       key_ascii,
  output logic             key_valid,
  output logic [CNT_W-1:0] press_cnt,
  output logic             press_pulse,
  output logic             ovf_err
);

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    POP  = 2'd1,
    PROC = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] byte_r;
  logic       brk;
  logic       ext;

  // The pop strobe is a pure decode of the state register, so it can never
  // glitch low outside the single POP cycle.
  assign nextdata_n = (state != POP);
  assign lut_code   = byte_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= WAIT;
      byte_r      <= 8'h00;
      brk         <= 1'b0;
      ext         <= 1'b0;
      key_code    <= 8'h00;
      key_ascii   <= 8'h00;
      key_valid   <= 1'b0;
      press_cnt   <= '0;
      press_pulse <= 1'b0;
      ovf_err     <= 1'b0;
    end else begin
      press_pulse <= 1'b0;
      case (state)
        WAIT: begin
          if (ps2_ready) begin
            byte_r <= ps2_data;
            state  <= POP;
          end
        end
        POP: begin
          state <= PROC;
        end
        PROC: begin
          state <= WAIT;
          if (byte_r == BREAK_CODE) begin
            brk <= 1'b1;
          end else if (byte_r == EXT_CODE) begin
            ext <= 1'b1;
          end else if (ext) begin
            // Extended keys are not supported; drop the byte and the prefixes.
            ext <= 1'b0;
            brk <= 1'b0;
          end else if (brk) begin
            brk <= 1'b0;
            if (key_valid && (byte_r == key_code)) begin
              key_valid <= 1'b0;
            end
          end else if (!(key_valid && (byte_r == key_code))) begin
            key_code    <= byte_r;
            key_ascii   <= lut_ascii;
            key_valid   <= 1'b1;
            press_cnt   <= press_cnt + 1'b1;
            press_pulse <= 1'b1;
          end
        end
        default: begin
          state <= WAIT;
        end
      endcase

      // Overflow means bytes were lost, so any pending prefix is meaningless.
      if (ps2_overflow) begin
        ovf_err <= 1'b1;
        brk     <= 1'b0;
        ext     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_kbd_scan_ctrl.sv
// Directed bench for kbd_scan_ctrl: a queue models the receiver FIFO and a
// small table models the ASCII lookup.
module tb_kbd_scan_ctrl;

  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic [7:0]       ps2_data;
  logic             ps2_ready;
  logic             ps2_overflow;
  logic             nextdata_n;
  logic [7:0]       lut_code;
  logic [7:0]       lut_ascii;
  logic [7:0]       key_code;
  logic [7:0]       key_ascii;
  logic             key_valid;
  logic [CNT_W-1:0] press_cnt;
  logic             press_pulse;
  logic             ovf_err;

  kbd_scan_ctrl #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .ps2_data     (ps2_data),
    .ps2_ready    (ps2_ready),
    .ps2_overflow (ps2_overflow),
    .nextdata_n   (nextdata_n),
    .lut_code     (lut_code),
    .lut_ascii    (lut_ascii),
    .key_code     (key_code),
    .key_ascii    (key_ascii),
    .key_valid    (key_valid),
    .press_cnt    (press_cnt),
    .press_pulse  (press_pulse),
    .ovf_err      (ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scan-code set 2 lookup used by the tests; anything else is unmapped.
  always_comb begin
    case (lut_code)
      8'h1C:   lut_ascii = 8'h61;
      8'h1B:   lut_ascii = 8'h73;
      8'h15:   lut_ascii = 8'h71;
      8'h16:   lut_ascii = 8'h31;
      8'h1E:   lut_ascii = 8'h32;
      default: lut_ascii = 8'hFF;
    endcase
  end

  logic [7:0] fifo[$];
  int pops;
  int pulses;
  int pulse_run;
  int pulse_max;
  int pop_run;
  int pop_max;
  int errors;
  int checks;

  // FIFO and strobe monitor, evaluated on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      fifo.delete();
    end else begin
      if (!nextdata_n) begin
        pops++;
        pop_run++;
        if (fifo.size() > 0) void'(fifo.pop_front());
      end else begin
        pop_run = 0;
      end
      if (pop_run > pop_max) pop_max = pop_run;
      if (press_pulse) begin
        pulses++;
        pulse_run++;
      end else begin
        pulse_run = 0;
      end
      if (pulse_run > pulse_max) pulse_max = pulse_run;
    end
    ps2_ready = (fifo.size() > 0);
    ps2_data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
  end

  task automatic wait_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic do_reset();
    wait_neg();
    rst = 1'b1;
    wait_neg();
    wait_neg();
    rst       = 1'b0;
    pops      = 0;
    pulses    = 0;
    pulse_run = 0;
    pulse_max = 0;
    pop_run   = 0;
    pop_max   = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int start;
    int budget;
    wait_neg();
    start = pops;
    fifo.push_back(b);
    ps2_ready = 1'b1;
    ps2_data  = fifo[0];
    budget = 0;
    while (pops == start && budget < 20) begin
      wait_neg();
      budget++;
    end
    if (pops == start) begin
      errors++;
      checks++;
      $display("FAIL pop_timeout: byte %0h never popped", b);
    end
    wait_neg();
    wait_neg();
  endtask

  typedef struct {
    bit         do_rst;
    logic [7:0] code;
    bit         exp_valid;
    logic [7:0] exp_code;
    logic [7:0] exp_ascii;
    int         exp_cnt;
    int         exp_pulses;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit r, logic [7:0] c, bit v, logic [7:0] kc,
                              logic [7:0] ka, int n, int p);
    vec_t t;
    t.do_rst = r; t.code = c; t.exp_valid = v; t.exp_code = kc;
    t.exp_ascii = ka; t.exp_cnt = n; t.exp_pulses = p;
    return t;
  endfunction

  initial begin
    rst = 1'b1; ps2_overflow = 1'b0; ps2_ready = 1'b0; ps2_data = 8'h00;
    pops = 0; pulses = 0; pulse_run = 0; pulse_max = 0;
    pop_run = 0; pop_max = 0; errors = 0; checks = 0;

    // Press / release
    vecs.push_back(mk(1, 8'h1C, 1, 8'h1C, 8'h61, 1, 1));
    vecs.push_back(mk(0, 8'hF0, 1, 8'h1C, 8'h61, 1, 1));
    vecs.push_back(mk(0, 8'h1C, 0, 8'h1C, 8'h61, 1, 1));
    // Typematic repeat
    vecs.push_back(mk(1, 8'h15, 1, 8'h15, 8'h71, 1, 1));
    vecs.push_back(mk(0, 8'h15, 1, 8'h15, 8'h71, 1, 1));
    vecs.push_back(mk(0, 8'h15, 1, 8'h15, 8'h71, 1, 1));
    vecs.push_back(mk(0, 8'h15, 1, 8'h15, 8'h71, 1, 1));
    vecs.push_back(mk(0, 8'hF0, 1, 8'h15, 8'h71, 1, 1));
    vecs.push_back(mk(0, 8'h15, 0, 8'h15, 8'h71, 1, 1));
    // Rollover
    vecs.push_back(mk(1, 8'h16, 1, 8'h16, 8'h31, 1, 1));
    vecs.push_back(mk(0, 8'h1E, 1, 8'h1E, 8'h32, 2, 2));
    vecs.push_back(mk(0, 8'hF0, 1, 8'h1E, 8'h32, 2, 2));
    vecs.push_back(mk(0, 8'h16, 1, 8'h1E, 8'h32, 2, 2));
    vecs.push_back(mk(0, 8'hF0, 1, 8'h1E, 8'h32, 2, 2));
    vecs.push_back(mk(0, 8'h1E, 0, 8'h1E, 8'h32, 2, 2));
    // Extended and unmapped
    vecs.push_back(mk(1, 8'hE0, 0, 8'h00, 8'h00, 0, 0));
    vecs.push_back(mk(0, 8'h75, 0, 8'h00, 8'h00, 0, 0));
    vecs.push_back(mk(0, 8'hE0, 0, 8'h00, 8'h00, 0, 0));
    vecs.push_back(mk(0, 8'hF0, 0, 8'h00, 8'h00, 0, 0));
    vecs.push_back(mk(0, 8'h75, 0, 8'h00, 8'h00, 0, 0));
    vecs.push_back(mk(0, 8'h76, 1, 8'h76, 8'hFF, 1, 1));

    do_reset();
    chk("rst_nextdata_n", int'(nextdata_n), 1);
    chk("rst_key_valid",  int'(key_valid), 0);
    chk("rst_key_code",   int'(key_code), 0);
    chk("rst_key_ascii",  int'(key_ascii), 0);
    chk("rst_press_cnt",  int'(press_cnt), 0);
    chk("rst_press_pulse", int'(press_pulse), 0);
    chk("rst_ovf_err",    int'(ovf_err), 0);
    chk("rst_lut_code",   int'(lut_code), 0);

    foreach (vecs[i]) begin
      if (vecs[i].do_rst && i != 0) do_reset();
      send_byte(vecs[i].code);
      $display("vec %0d byte %0h: valid=%0d code=%0h ascii=%0h cnt=%0d pulses=%0d",
               i, vecs[i].code, key_valid, key_code, key_ascii, press_cnt, pulses);
      chk($sformatf("v%0d_key_valid", i), int'(key_valid), int'(vecs[i].exp_valid));
      chk($sformatf("v%0d_key_code", i),  int'(key_code),  int'(vecs[i].exp_code));
      chk($sformatf("v%0d_key_ascii", i), int'(key_ascii), int'(vecs[i].exp_ascii));
      chk($sformatf("v%0d_press_cnt", i), int'(press_cnt), vecs[i].exp_cnt);
      chk($sformatf("v%0d_pulses", i),    pulses,          vecs[i].exp_pulses);
      chk($sformatf("v%0d_pulse_width", i), pulse_max,     vecs[i].exp_pulses > 0 ? 1 : 0);
      chk($sformatf("v%0d_pop_width", i), pop_max,         1);
      if (i == 2) chk("press_release_pops", pops, 3);
    end

    // Counter wrap: 256 distinct makes bring an 8-bit counter back to zero
    do_reset();
    for (int n = 0; n < 256; n++) send_byte((n % 2 == 0) ? 8'h1C : 8'h1B);
    $display("wrap: cnt=%0d code=%0h pulses=%0d", press_cnt, key_code, pulses);
    chk("wrap_press_cnt", int'(press_cnt), 0);
    chk("wrap_key_code",  int'(key_code), 8'h1B);
    chk("wrap_key_ascii", int'(key_ascii), 8'h73);
    chk("wrap_pulses",    pulses, 256);
    chk("wrap_pops",      pops, 256);

    // Overflow after F0 discards the break prefix
    do_reset();
    send_byte(8'hF0);
    wait_neg();
    ps2_overflow = 1'b1;
    wait_neg();
    ps2_overflow = 1'b0;
    chk("ovf_err_set", int'(ovf_err), 1);
    send_byte(8'h1C);
    $display("ovf: ovf_err=%0d valid=%0d code=%0h cnt=%0d", ovf_err, key_valid, key_code, press_cnt);
    chk("ovf_make_valid", int'(key_valid), 1);
    chk("ovf_make_code",  int'(key_code), 8'h1C);
    chk("ovf_make_cnt",   int'(press_cnt), 1);
    chk("ovf_err_sticky", int'(ovf_err), 1);

    // Reset asserted during the POP cycle
    do_reset();
    send_byte(8'h1C);
    wait_neg();
    fifo.push_back(8'h1B);
    ps2_ready = 1'b1;
    ps2_data  = 8'h1B;
    begin
      int budget = 0;
      while (nextdata_n && budget < 20) begin
        wait_neg();
        budget++;
      end
    end
    chk("pop_seen_before_rst", int'(nextdata_n), 0);
    rst = 1'b1;
    wait_neg();
    $display("rst_in_pop: nextdata_n=%0d valid=%0d code=%0h cnt=%0d", nextdata_n, key_valid, key_code, press_cnt);
    chk("rstpop_nextdata_n", int'(nextdata_n), 1);
    chk("rstpop_key_valid",  int'(key_valid), 0);
    chk("rstpop_key_code",   int'(key_code), 0);
    chk("rstpop_key_ascii",  int'(key_ascii), 0);
    chk("rstpop_press_cnt",  int'(press_cnt), 0);
    chk("rstpop_lut_code",   int'(lut_code), 0);
    rst = 1'b0;
    pops = 0;
    pulses = 0;
    for (int k = 0; k < 6; k++) wait_neg();
    chk("rstpop_no_more_pops", pops, 0);
    chk("rstpop_no_update",    int'(key_valid), 0);
    chk("rstpop_no_pulse",     pulses, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
